// File: rtl/conv_window_reader.sv
// conv_window_reader
// Streams an int4 feature map out of the RAM read port, one pixel per cycle,
// and presents every 3x3 stride-1 window (no padding) to the conv MAC stage.
// Two IMG_W-deep line buffers hold the previous two rows, so each pixel is
// fetched from RAM exactly once per frame.
module conv_window_reader #(
  parameter int WIDTH     = 4,
  parameter int ADDR_BIT  = 10,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_BIT-1:0]   ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic                  win_valid,
  output logic [9*WIDTH-1:0]    win_data
);

  localparam int N  = IMG_W * IMG_H;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_BIT-1:0] BASE_L = ADDR_BIT'(BASE_ADDR);

  if (BASE_ADDR + IMG_W * IMG_H > 2 ** ADDR_BIT) begin : g_addr_range_err
    $error("conv_window_reader: frame does not fit in RAM address space");
  end
  if (IMG_W < 3 || IMG_H < 3) begin : g_size_err
    $error("conv_window_reader: IMG_W and IMG_H must be at least 3");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [NW-1:0]     addr_cnt;

  // stage p0: pixel present on ram_dout, tagged with its (row, col)
  logic              vld_p0;
  logic [CW-1:0]     col_p0;
  logic [RW-1:0]     row_p0;

  // stage p1: window registers and line buffers after capturing the pixel
  logic              vld_p1;
  logic [WIDTH-1:0]  win_p1 [9];
  logic [WIDTH-1:0]  lb1 [IMG_W];
  logic [WIDTH-1:0]  lb2 [IMG_W];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: DRAIN leaves once the final pixel has been captured.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (addr_cnt == NW'(N - 1)) state_nxt = DRAIN;
      DRAIN:   if (!vld_p0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == READ) || (state == DRAIN);
  assign done     = (state == FIN);
  assign ram_en   = (state == READ);
  assign ram_addr = BASE_L + ADDR_BIT'(addr_cnt);

  // Address counter: held at zero while idle, one address per READ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               addr_cnt <= '0;
    else if (state == IDLE)   addr_cnt <= '0;
    else if (state == READ)   addr_cnt <= addr_cnt + NW'(1);
  end

  // Returned-pixel tracking: ram_dout is valid one cycle after ram_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      col_p0 <= '0;
      row_p0 <= '0;
    end else begin
      vld_p0 <= ram_en;
      if (state == IDLE) begin
        col_p0 <= '0;
        row_p0 <= '0;
      end else if (vld_p0) begin
        if (col_p0 == CW'(IMG_W - 1)) begin
          col_p0 <= '0;
          row_p0 <= row_p0 + RW'(1);
        end else begin
          col_p0 <= col_p0 + CW'(1);
        end
      end
    end
  end

  // Window shift and line-buffer update; a window is complete only once
  // three full columns of the current row band exist, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < 9; k++) win_p1[k] <= '0;
      for (int c = 0; c < IMG_W; c++) begin
        lb1[c] <= '0;
        lb2[c] <= '0;
      end
    end else begin
      vld_p1 <= vld_p0 && (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));
      if (vld_p0) begin
        win_p1[0]   <= win_p1[1];
        win_p1[1]   <= win_p1[2];
        win_p1[2]   <= lb2[col_p0];
        win_p1[3]   <= win_p1[4];
        win_p1[4]   <= win_p1[5];
        win_p1[5]   <= lb1[col_p0];
        win_p1[6]   <= win_p1[7];
        win_p1[7]   <= win_p1[8];
        win_p1[8]   <= ram_dout;
        lb2[col_p0] <= lb1[col_p0];
        lb1[col_p0] <= ram_dout;
      end
    end
  end

  assign win_valid = vld_p1;

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign win_data[k*WIDTH +: WIDTH] = win_p1[k];
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader on a 5x4 frame with mem[a] = a % 16.
module tb_conv_window_reader;

  localparam int WIDTH    = 4;
  localparam int ADDR_BIT = 10;
  localparam int IMG_W    = 5;
  localparam int IMG_H    = 4;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int NWIN     = (IMG_W - 2) * (IMG_H - 2);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 ram_en;
  logic [ADDR_BIT-1:0]  ram_addr;
  logic [WIDTH-1:0]     ram_dout;
  logic                 win_valid;
  logic [9*WIDTH-1:0]   win_data;

  conv_window_reader #(
    .WIDTH(WIDTH), .ADDR_BIT(ADDR_BIT), .IMG_W(IMG_W), .IMG_H(IMG_H), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .win_valid(win_valid), .win_data(win_data)
  );

  always #5 clk = ~clk;

  // Read port of the RAM: registered output, one cycle latency.
  logic [WIDTH-1:0] mem [1 << ADDR_BIT];
  initial begin
    for (int a = 0; a < (1 << ADDR_BIT); a++) mem[a] = WIDTH'(a % 16);
    ram_dout = '0;
  end
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  typedef struct {
    int              addr;   // address whose capture completes the window
    logic [35:0]     win;
  } win_vec_t;

  win_vec_t wtab [NWIN];
  int total = 0;
  int fails = 0;

  function automatic logic [35:0] pack9(int s0, int s1, int s2, int s3, int s4,
                                        int s5, int s6, int s7, int s8);
    logic [35:0] v;
    v[3:0]   = 4'(s0); v[7:4]   = 4'(s1); v[11:8]  = 4'(s2);
    v[15:12] = 4'(s3); v[19:16] = 4'(s4); v[23:20] = 4'(s5);
    v[27:24] = 4'(s6); v[31:28] = 4'(s7); v[35:32] = 4'(s8);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"},      64'(busy),      64'd0);
    check({tag, ".done"},      64'(done),      64'd0);
    check({tag, ".ram_en"},    64'(ram_en),    64'd0);
    check({tag, ".ram_addr"},  64'(ram_addr),  64'd0);
    check({tag, ".win_valid"}, 64'(win_valid), 64'd0);
    check({tag, ".win_data"},  64'(win_data),  64'd0);
  endtask

  // Runs one frame from a start pulse. Cycle 0 is the first cycle in READ.
  task automatic run_frame(input string tag, input bit mid_start, input bit linger);
    int  addr_cyc [NPIX];
    bit  wv_log [64];
    int  boundary [6];
    int  nissue, nwin, ndone, done_cyc, last_win_cyc, cyc, stop_cyc;
    boundary = '{5, 6, 10, 11, 15, 16};
    for (int i = 0; i < NPIX; i++) addr_cyc[i] = -100;
    for (int i = 0; i < 64; i++) wv_log[i] = 1'b0;
    nissue = 0; nwin = 0; ndone = 0; done_cyc = -1; last_win_cyc = -1;
    stop_cyc = 60;

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, ".busy_rise"}, 64'(busy), 64'd1);

    cyc = 0;
    while (cyc < stop_cyc) begin
      start = (mid_start && cyc == 5) ? 1'b1 : 1'b0;
      if (ram_en) begin
        if (nissue < NPIX) begin
          check({tag, ".addr"}, 64'(ram_addr), 64'(nissue));
          addr_cyc[nissue] = cyc;
        end
        nissue++;
      end
      wv_log[cyc] = win_valid;
      if (win_valid) begin
        if (nwin < NWIN) begin
          check({tag, ".win_data"}, 64'(win_data), 64'(wtab[nwin].win));
          check({tag, ".win_latency"}, 64'(cyc), 64'(addr_cyc[wtab[nwin].addr] + 2));
        end
        last_win_cyc = cyc;
        nwin++;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_cyc = cyc;
          check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
          stop_cyc = linger ? cyc + 5 : cyc + 1;
        end
      end
      cyc++;
      if (cyc < stop_cyc) @(negedge clk);
    end
    start = 1'b0;

    check({tag, ".addr_count"},  64'(nissue), 64'(NPIX));
    check({tag, ".win_count"},   64'(nwin),   64'(NWIN));
    check({tag, ".done_count"},  64'(ndone),  64'd1);
    check({tag, ".done_cycle"},  64'(done_cyc), 64'd22);
    check({tag, ".last_win_before_done"}, 64'(last_win_cyc), 64'(done_cyc - 1));
    if (nissue >= NPIX) begin
      for (int i = 0; i < 6; i++)
        check({tag, ".no_win_col01"}, 64'(wv_log[addr_cyc[boundary[i]] + 2]), 64'd0);
    end
    if (linger) check({tag, ".idle_after"}, 64'({busy, ram_en}), 64'd0);
  endtask

  initial begin
    int seen;
    wtab[0] = '{12, pack9(0, 1, 2, 5, 6, 7, 10, 11, 12)};
    wtab[1] = '{13, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13)};
    wtab[2] = '{14, pack9(2, 3, 4, 7, 8, 9, 12, 13, 14)};
    wtab[3] = '{17, pack9(5, 6, 7, 10, 11, 12, 15, 0, 1)};
    wtab[4] = '{18, pack9(6, 7, 8, 11, 12, 13, 0, 1, 2)};
    wtab[5] = '{19, pack9(7, 8, 9, 12, 13, 14, 1, 2, 3)};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_frame("frame1", 1'b0, 1'b1);
    run_frame("mid_start", 1'b1, 1'b0);
    run_frame("back_to_back", 1'b0, 1'b1);

    // Reset while address 9 is being issued.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      if (ram_en && ram_addr == 10'd9) seen = 1;
      else @(negedge clk);
    end
    check("abort.reached_addr9", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort.no_done", 64'(seen), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort_release");

    run_frame("after_abort", 1'b0, 1'b1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
